// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED step scheduler and its button debouncer.
// Optional auto-repeat is enabled with LED_SCHED_AUTOREPEAT_EN (see btn_debounce).
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DEB_PRESS   = 2'd1,
      HELD        = 2'd2,
      DEB_RELEASE = 2'd3
   } btn_state_e;

   localparam logic STEP_SRC_MANUAL = 1'b0;
   localparam logic STEP_SRC_AUTO   = 1'b1;

endpackage

// File: rtl/led_step_scheduler_btn_debounce.sv
// Button synchronizer + debounce FSM; one manual_req pulse per accepted press.
// LED_SCHED_AUTOREPEAT_EN adds hold-to-repeat requests while the button stays HELD.
module btn_debounce
   import led_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16
`ifdef LED_SCHED_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 32,
   parameter int REPEAT_PERIOD   = 8
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic button,
   output logic manual_req,
   output logic btn_held
);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   btn_s;
   btn_state_e             state_r;
   logic [CNT_W-1:0]       deb_cnt_r;
   logic                   manual_req_r;
   logic                   btn_held_r;

`ifdef LED_SCHED_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
   logic [CNT_W-1:0] hold_cnt_r;
   logic             rep_phase_r;
`endif

   // Metastability synchronizer for the raw button.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], button};
      end
   end

   assign btn_s = sync_r[SYNC_STAGES-1];

   // Debounce FSM: a level change is accepted on the sample after the count hits its limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         deb_cnt_r    <= '0;
         manual_req_r <= 1'b0;
         btn_held_r   <= 1'b0;
`ifdef LED_SCHED_AUTOREPEAT_EN
         hold_cnt_r   <= '0;
         rep_phase_r  <= 1'b0;
`endif
      end else begin
         manual_req_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (btn_s) begin
                  state_r   <= DEB_PRESS;
                  deb_cnt_r <= CNT_ONE;
               end else begin
                  deb_cnt_r <= '0;
               end
            end
            DEB_PRESS: begin
               if (!btn_s) begin
                  state_r   <= IDLE;
                  deb_cnt_r <= '0;
               end else if (deb_cnt_r >= DEB_LIMIT) begin
                  state_r      <= HELD;
                  deb_cnt_r    <= '0;
                  manual_req_r <= 1'b1;
                  btn_held_r   <= 1'b1;
`ifdef LED_SCHED_AUTOREPEAT_EN
                  hold_cnt_r   <= '0;
                  rep_phase_r  <= 1'b0;
`endif
               end else begin
                  deb_cnt_r <= deb_cnt_r + CNT_ONE;
               end
            end
            HELD: begin
               if (!btn_s) begin
                  state_r   <= DEB_RELEASE;
                  deb_cnt_r <= CNT_ONE;
               end else begin
                  deb_cnt_r <= '0;
`ifdef LED_SCHED_AUTOREPEAT_EN
                  // First repeat after the delay, then one per period.
                  if (hold_cnt_r == (rep_phase_r ? REP_PERIOD_LAST : REP_DELAY_LAST)) begin
                     manual_req_r <= 1'b1;
                     hold_cnt_r   <= '0;
                     rep_phase_r  <= 1'b1;
                  end else begin
                     hold_cnt_r   <= hold_cnt_r + CNT_ONE;
                  end
`endif
               end
            end
            DEB_RELEASE: begin
               if (btn_s) begin
                  state_r   <= HELD;
                  deb_cnt_r <= '0;
`ifdef LED_SCHED_AUTOREPEAT_EN
                  hold_cnt_r  <= '0;
                  rep_phase_r <= 1'b0;
`endif
               end else if (deb_cnt_r >= DEB_LIMIT) begin
                  state_r    <= IDLE;
                  deb_cnt_r  <= '0;
                  btn_held_r <= 1'b0;
               end else begin
                  deb_cnt_r <= deb_cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r   <= IDLE;
               deb_cnt_r <= '0;
            end
         endcase
      end
   end

   assign manual_req = manual_req_r;
   assign btn_held   = btn_held_r;

endmodule

// File: rtl/led_step_scheduler.sv
// Arbitrates debounced button presses and the auto-advance timer onto one step pulse.
// Define LED_SCHED_AUTOREPEAT_EN to enable hold-to-repeat manual steps.
module led_step_scheduler
   import led_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int AUTO_PERIOD     = 16,
   parameter int CNT_W           = 16
`ifdef LED_SCHED_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 32,
   parameter int REPEAT_PERIOD   = 8
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic button,
   input  logic we,
   input  logic mode_auto,
   output logic step,
   output logic step_src,
   output logic btn_held
);

   localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic             manual_req_s;
   logic             btn_held_s;
   logic             auto_req_s;
   logic [CNT_W-1:0] auto_cnt_r;
   logic             step_r;
   logic             step_src_r;

`ifdef LED_SCHED_AUTOREPEAT_EN
   btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
   ) u_btn (
      .clk       (clk),
      .rst       (rst),
      .button    (button),
      .manual_req(manual_req_s),
      .btn_held  (btn_held_s)
   );
`else
   btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_btn (
      .clk       (clk),
      .rst       (rst),
      .button    (button),
      .manual_req(manual_req_s),
      .btn_held  (btn_held_s)
   );
`endif

   // Terminal count only ticks while the timer is actually advancing.
   always_comb begin
      auto_req_s = 1'b0;
      if (mode_auto && we && (auto_cnt_r == AUTO_LAST)) begin
         auto_req_s = 1'b1;
      end else begin
         auto_req_s = 1'b0;
      end
   end

   // Auto-advance timer: cleared when disabled, frozen while stepping is not permitted.
   always_ff @(posedge clk) begin
      if (rst) begin
         auto_cnt_r <= '0;
      end else if (!mode_auto) begin
         auto_cnt_r <= '0;
      end else if (we) begin
         auto_cnt_r <= (auto_cnt_r == AUTO_LAST) ? '0 : auto_cnt_r + CNT_ONE;
      end else begin
         auto_cnt_r <= auto_cnt_r;
      end
   end

   // Registered step with manual priority; gated requests are dropped, not queued.
   always_ff @(posedge clk) begin
      if (rst) begin
         step_r     <= 1'b0;
         step_src_r <= STEP_SRC_MANUAL;
      end else begin
         step_r     <= (manual_req_s | auto_req_s) & we;
         step_src_r <= (!manual_req_s && auto_req_s) ? STEP_SRC_AUTO : STEP_SRC_MANUAL;
      end
   end

   assign step     = step_r;
   assign step_src = step_src_r;
   assign btn_held = btn_held_s;

endmodule

// File: tb/tb_led_step_scheduler.sv
// Self-checking bench: directed scenarios plus randomized segments against a run-length reference model.
module tb_led_step_scheduler;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int PER  = 16;
   localparam int CW   = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic button = 1'b0;
   logic we = 1'b0;
   logic mode_auto = 1'b0;
   logic step;
   logic step_src;
   logic btn_held;

   always #5 clk = ~clk;

   led_step_scheduler #(
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(DEB),
      .AUTO_PERIOD    (PER),
      .CNT_W          (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .button   (button),
      .we       (we),
      .mode_auto(mode_auto),
      .step     (step),
      .step_src (step_src),
      .btn_held (btn_held)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model: raw samples in flight, accepted level, run of opposite samples
   bit q_raw[$];
   bit m_level = 1'b0;
   int m_run   = 0;
   bit m_mreq  = 1'b0;
   int m_acnt  = 0;
   bit e_step  = 1'b0;
   bit e_src   = 1'b0;

   int cyc = 0;
   int step_count = 0;
   int first_step = -1;
   int last_step  = -1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic model_edge(input bit b, input bit w, input bit m, input bit r);
      bit bs;
      bit areq;
      if (r) begin
         q_raw.delete();
         for (int i = 0; i < SYNC; i++) q_raw.push_back(1'b0);
         m_level = 1'b0;
         m_run   = 0;
         m_mreq  = 1'b0;
         m_acnt  = 0;
         e_step  = 1'b0;
         e_src   = 1'b0;
         return;
      end
      bs = q_raw.pop_front();
      q_raw.push_back(b);
      areq = 1'b0;
      if (!m) begin
         m_acnt = 0;
      end else if (w) begin
         areq   = (m_acnt == PER - 1);
         m_acnt = (m_acnt + 1) % PER;
      end
      e_step = (m_mreq || areq) && w;
      e_src  = m_mreq ? 1'b0 : 1'b1;
      m_mreq = 1'b0;
      // a level flips after DEB+1 consecutive opposite synchronized samples
      if (bs != m_level) begin
         m_run++;
         if (m_run == DEB + 1) begin
            m_level = bs;
            m_run   = 0;
            m_mreq  = bs;
         end
      end else begin
         m_run = 0;
      end
   endtask

   task automatic tick(input bit b, input bit w, input bit m, input bit r);
      button    = b;
      we        = w;
      mode_auto = m;
      rst       = r;
      @(posedge clk);
      model_edge(b, w, m, r);
      #1;
      check_eq("step", step, e_step);
      if (e_step) check_eq("step_src", step_src, e_src);
      check_eq("btn_held", btn_held, m_level);
      if (step === 1'b1) begin
         step_count++;
         if (first_step < 0) first_step = cyc;
         last_step = cyc;
      end
      cyc++;
   endtask

   task automatic window_start();
      cyc        = 0;
      step_count = 0;
      first_step = -1;
      last_step  = -1;
   endtask

   int seg_len;
   bit seg_b, seg_w, seg_m, seg_r;

   initial begin
      for (int i = 0; i < SYNC; i++) q_raw.push_back(1'b0);

      // reset held with button pressed, then press accepted after reset
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b1);
      window_start();
      for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("rst_latency", first_step, 7);
      check_eq("rst_steps", step_count, 1);

      // glitch rejection and release bounce
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
      window_start();
      for (int i = 0; i < 3; i++)  tick(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++)  tick(1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("glitch_steps", step_count, 0);
      window_start();
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++)  tick(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("bounce_steps", step_count, 1);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);

      // auto mode, freeze, resume
      window_start();
      for (int i = 0; i < 64; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("auto_steps", step_count, 4);
      check_eq("auto_first", first_step, 15);
      check_eq("auto_last", last_step, 63);
      window_start();
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("frozen_steps", step_count, 0);
      window_start();
      for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("resume_steps", step_count, 1);
      check_eq("resume_at", last_step, 15);

      // manual press aligned with the auto terminal count
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      window_start();
      for (int i = 0; i < 24; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 26; i++) begin
         tick(1'b1, 1'b1, 1'b1, 1'b0);
         if (cyc - 1 == 31 && step === 1'b1) check_eq("coll_src", step_src, 0);
      end
      check_eq("coll_steps", step_count, 3);
      check_eq("coll_next", last_step, 47);
      for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);

      // permission gating across a held press
      window_start();
      for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++)  tick(1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("gated_steps", step_count, 0);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
      window_start();
      for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("regate_steps", step_count, 1);

      // randomized segments
      for (int s = 0; s < 80; s++) begin
         seg_len = $urandom_range(1, 24);
         seg_b   = 1'($urandom_range(0, 1));
         seg_w   = ($urandom_range(0, 9) != 0);
         seg_m   = ($urandom_range(0, 3) != 0);
         seg_r   = ($urandom_range(0, 29) == 0);
         for (int k = 0; k < seg_len; k++) tick(seg_b, seg_w, seg_m, seg_r && (k == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
